// File: rtl/wptr_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wptr_level_ctrl
// Description : Write-domain pointer, fill-level and flag controller for an
//               async FIFO (binary/Gray pointers, full, almost_full, overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_level_ctrl #(
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 w_en,
    input  logic                 ovf_clr,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    output logic                 w_accept,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH:0] c_depth       = (PTR_WIDTH+1)'(1 << PTR_WIDTH);
    localparam logic [PTR_WIDTH:0] c_afull_level = (PTR_WIDTH+1)'(AFULL_THRESH);

    logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
    logic [PTR_WIDTH:0] wlevel_q, wlevel_d;
    logic               full_q, full_d;
    logic               almost_full_q, almost_full_d;
    logic               overflow_q, overflow_d;

    logic [PTR_WIDTH:0] w_b_rptr_sync;
    logic [PTR_WIDTH:0] w_g_rptr_full;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi <= PTR_WIDTH; gi++) begin : g_g2b
            assign w_b_rptr_sync[gi] = ^g_rptr_sync[PTR_WIDTH:gi];
        end
    endgenerate

    // Writer is exactly one lap ahead when the top two Gray bits are inverted.
    assign w_g_rptr_full = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};

    assign w_accept = w_en & ~full_q;

    always_comb begin
        b_wptr_d      = b_wptr_q + (PTR_WIDTH+1)'(w_accept);
        g_wptr_d      = b_wptr_d ^ (b_wptr_d >> 1);
        wlevel_d      = b_wptr_d - w_b_rptr_sync;
        full_d        = (g_wptr_d == w_g_rptr_full);
        almost_full_d = (wlevel_d >= c_afull_level);
        overflow_d    = overflow_q;
        if (w_en && full_q) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr_q      <= '0;
            g_wptr_q      <= '0;
            wlevel_q      <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            b_wptr_q      <= b_wptr_d;
            g_wptr_q      <= g_wptr_d;
            wlevel_q      <= wlevel_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign waddr       = b_wptr_q[PTR_WIDTH-1:0];
    assign b_wptr      = b_wptr_q;
    assign g_wptr      = g_wptr_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wlevel      = wlevel_q;
    assign overflow    = overflow_q;

    a_full_level : assert property (@(posedge wclk) disable iff (!wrst_n)
        full_q == (wlevel_q == c_depth));

endmodule
`default_nettype wire
